// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the memory access controller and the cache-fill logic
// that will later reuse the burst-length clamp.
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  function automatic int addr_width(input int mem_size);
    int result;
    result = (mem_size > 1) ? $clog2(mem_size) : 1;
    return result;
  endfunction

  function automatic int len_width(input int max_burst);
    int result;
    result = $clog2(max_burst) + 1;
    return result;
  endfunction

  // A zero length still moves one word; oversize requests are cut to the burst limit.
  function automatic int clamp_len(input int len, input int max_burst);
    int result;
    result = len;
    if (len < 1)
      result = 1;
    else if (len > max_burst)
      result = max_burst;
    return result;
  endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// CPU request/response channel plus the level-sensitive memory bus, bundled so the
// controller sees one port; master is the controller's view, slave the environment's.
interface mem_access_ctrl_if
  import mem_ctrl_pkg::*;
#(
  parameter int MEM_WIDTH = 32,
  parameter int MEM_SIZE  = 256,
  parameter int MAX_BURST = 4
);
  localparam int AW = addr_width(MEM_SIZE);
  localparam int LW = len_width(MAX_BURST);

  logic                 cpu_req_valid;
  logic                 cpu_req_ready;
  logic                 cpu_req_we;
  logic [AW-1:0]        cpu_req_addr;
  logic [MEM_WIDTH-1:0] cpu_req_wdata;
  logic [LW-1:0]        cpu_req_len;
  logic                 cpu_resp_valid;
  logic [MEM_WIDTH-1:0] cpu_resp_rdata;
  logic                 busy;
  logic [AW-1:0]        mem_addr;
  logic                 mem_read_en;
  logic                 mem_write_en;
  logic [MEM_WIDTH-1:0] mem_write_val;
  logic [MEM_WIDTH-1:0] mem_read_val;

  modport master (
    input  cpu_req_valid, cpu_req_we, cpu_req_addr, cpu_req_wdata, cpu_req_len,
    input  mem_read_val,
    output cpu_req_ready, cpu_resp_valid, cpu_resp_rdata, busy,
    output mem_addr, mem_read_en, mem_write_en, mem_write_val
  );

  modport slave (
    output cpu_req_valid, cpu_req_we, cpu_req_addr, cpu_req_wdata, cpu_req_len,
    output mem_read_val,
    input  cpu_req_ready, cpu_resp_valid, cpu_resp_rdata, busy,
    input  mem_addr, mem_read_en, mem_write_en, mem_write_val
  );

endinterface

// File: rtl/mem_wait_timer.sv
// Loadable down-counter that times how long a memory strobe is held; done is
// high while the count sits at zero.
module mem_wait_timer #(
  parameter int WAIT_CYCLES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic en,
  output logic done
);
  localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(WAIT_CYCLES - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      count <= '0;
    else if (load)
      count <= RELOAD;
    else if (en && (count != '0))
      count <= count - CW'(1);
  end

  assign done = (count == '0);

endmodule

// File: rtl/mem_access_ctrl.sv
// Bus initiator between the CPU load/store/fetch stage and a word-addressed memory:
// one request at a time, a strobe-free setup cycle, then WAIT_CYCLES of strobe per word.
module mem_access_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int MEM_WIDTH   = 32,
  parameter int MEM_SIZE    = 256,
  parameter int WAIT_CYCLES = 2,
  parameter int MAX_BURST   = 4
) (
  input logic             clk,
  input logic             reset,
  mem_access_ctrl_if.master bus
);
  localparam int AW = addr_width(MEM_SIZE);
  localparam int LW = len_width(MAX_BURST);
  localparam logic [AW-1:0] LAST_ADDR = AW'(MEM_SIZE - 1);

  state_t               state, next_state;
  logic                 we_q;
  logic [LW-1:0]        remaining;
  logic [AW-1:0]        addr_q;
  logic [MEM_WIDTH-1:0] wval_q;
  logic                 resp_valid_q;
  logic [MEM_WIDTH-1:0] rdata_q;
  logic                 accept;
  logic                 timer_load;
  logic                 timer_en;
  logic                 timer_done;
  logic                 word_done;

  mem_wait_timer #(.WAIT_CYCLES(WAIT_CYCLES)) u_timer (
    .clk   (clk),
    .reset (reset),
    .load  (timer_load),
    .en    (timer_en),
    .done  (timer_done)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state <= IDLE;
    else
      state <= next_state;
  end

  always_comb begin
    next_state = state;
    accept     = 1'b0;
    timer_load = 1'b0;
    word_done  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.cpu_req_valid) begin
          accept     = 1'b1;
          next_state = SETUP;
        end
      end
      SETUP: begin
        timer_load = 1'b1;
        next_state = ACCESS;
      end
      ACCESS: begin
        if (timer_done) begin
          word_done  = 1'b1;
          next_state = (remaining > LW'(1)) ? SETUP : IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // The address advances only between burst words, so it is already stable when SETUP begins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      we_q         <= 1'b0;
      remaining    <= '0;
      addr_q       <= '0;
      wval_q       <= '0;
      resp_valid_q <= 1'b0;
      rdata_q      <= '0;
    end else begin
      resp_valid_q <= word_done;
      if (accept) begin
        addr_q    <= bus.cpu_req_addr;
        we_q      <= bus.cpu_req_we;
        wval_q    <= bus.cpu_req_wdata;
        remaining <= bus.cpu_req_we ? LW'(1)
                                    : LW'(clamp_len(int'(bus.cpu_req_len), MAX_BURST));
      end
      if (word_done) begin
        rdata_q   <= we_q ? '0 : bus.mem_read_val;
        remaining <= remaining - LW'(1);
        if (remaining > LW'(1))
          addr_q <= (addr_q == LAST_ADDR) ? '0 : addr_q + AW'(1);
      end
    end
  end

  assign timer_en = (state == ACCESS);

  // Strobes decode straight from the state register so an async reset drops them at once.
  assign bus.mem_read_en    = (state == ACCESS) && !we_q;
  assign bus.mem_write_en   = (state == ACCESS) && we_q;
  assign bus.mem_addr       = addr_q;
  assign bus.mem_write_val  = wval_q;
  assign bus.cpu_req_ready  = (state == IDLE);
  assign bus.busy           = (state != IDLE);
  assign bus.cpu_resp_valid = resp_valid_q;
  assign bus.cpu_resp_rdata = rdata_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with a behavioural memory preloaded to mem[i] = i + 0x100.
module tb_mem_access_ctrl;

  localparam int MEM_WIDTH   = 32;
  localparam int MEM_SIZE    = 256;
  localparam int WAIT_CYCLES = 2;
  localparam int MAX_BURST   = 4;

  logic clk = 1'b0;
  logic reset;
  logic preload;

  always #5 clk = ~clk;

  mem_access_ctrl_if #(
    .MEM_WIDTH (MEM_WIDTH),
    .MEM_SIZE  (MEM_SIZE),
    .MAX_BURST (MAX_BURST)
  ) bus ();

  mem_access_ctrl #(
    .MEM_WIDTH   (MEM_WIDTH),
    .MEM_SIZE    (MEM_SIZE),
    .WAIT_CYCLES (WAIT_CYCLES),
    .MAX_BURST   (MAX_BURST)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [31:0] mem [MEM_SIZE];

  assign bus.mem_read_val = mem[bus.mem_addr];

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < MEM_SIZE; i++)
        mem[i] <= 32'h100 + 32'(i);
    end else if (bus.mem_write_en) begin
      mem[bus.mem_addr] <= bus.mem_write_val;
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          resp_cyc [$];
  logic [31:0] resp_dat [$];
  int          overlap_cnt = 0;
  int          wr_cnt = 0;
  int          bad_wr_cnt = 0;
  logic [7:0]  wr_allowed = 8'd0;

  // Records every response and any strobe activity that should never occur.
  always @(negedge clk) begin
    if (bus.cpu_resp_valid) begin
      resp_cyc.push_back(cyc);
      resp_dat.push_back(bus.cpu_resp_rdata);
    end
    if (bus.mem_read_en && bus.mem_write_en)
      overlap_cnt++;
    if (bus.mem_write_en) begin
      wr_cnt++;
      if (bus.mem_addr != wr_allowed)
        bad_wr_cnt++;
    end
  end

  int checks = 0;
  int passes = 0;
  int start = 0;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp)
      passes++;
    else
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [31:0] respDatAt(input int i);
    return (i < resp_dat.size()) ? resp_dat[i] : 32'hDEAD_0000;
  endfunction

  function automatic logic [31:0] respCycAt(input int i);
    return (i < resp_cyc.size()) ? 32'(resp_cyc[i] - start) : 32'hFFFF_FFFF;
  endfunction

  // Presents a request; start is set so the first negedge after the accept edge is cycle 1.
  task automatic applyStimulus(input logic we, input logic [7:0] addr, input logic [31:0] wdata,
                               input logic [2:0] len, input bit hold);
    resp_cyc.delete();
    resp_dat.delete();
    @(negedge clk);
    bus.cpu_req_we    = we;
    bus.cpu_req_addr  = addr;
    bus.cpu_req_wdata = wdata;
    bus.cpu_req_len   = len;
    bus.cpu_req_valid = 1'b1;
    @(posedge clk);
    #1;
    start = cyc - 1;
    if (!hold)
      bus.cpu_req_valid = 1'b0;
  endtask

  task automatic runCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_ready"},    32'(bus.cpu_req_ready),  32'd1);
    checkOutput({tag, "_busy"},     32'(bus.busy),           32'd0);
    checkOutput({tag, "_rvalid"},   32'(bus.cpu_resp_valid), 32'd0);
    checkOutput({tag, "_rdata"},    bus.cpu_resp_rdata,      32'd0);
    checkOutput({tag, "_mem_addr"}, 32'(bus.mem_addr),       32'd0);
    checkOutput({tag, "_wval"},     bus.mem_write_val,       32'd0);
    checkOutput({tag, "_rd_en"},    32'(bus.mem_read_en),    32'd0);
    checkOutput({tag, "_wr_en"},    32'(bus.mem_write_en),   32'd0);
  endtask

  logic [31:0] burst_exp [4] = '{32'h1FE, 32'h1FF, 32'h100, 32'h101};

  initial begin
    reset             = 1'b1;
    preload           = 1'b1;
    bus.cpu_req_valid = 1'b0;
    bus.cpu_req_we    = 1'b0;
    bus.cpu_req_addr  = '0;
    bus.cpu_req_wdata = '0;
    bus.cpu_req_len   = '0;
    repeat (2) @(negedge clk);
    preload = 1'b0;
    reset   = 1'b0;
    @(negedge clk);
    checkResetValues("reset");

    // Single read: strobe in cycles 2-3, response and ready in cycle 4.
    applyStimulus(1'b0, 8'd5, 32'h0, 3'd1, 1'b0);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      checkOutput($sformatf("rd1_rd_en_c%0d", k), 32'(bus.mem_read_en), 32'((k == 2) || (k == 3)));
      checkOutput($sformatf("rd1_rvalid_c%0d", k), 32'(bus.cpu_resp_valid), 32'(k == 4));
      checkOutput($sformatf("rd1_ready_c%0d", k), 32'(bus.cpu_req_ready), 32'(k >= 4));
    end
    checkOutput("rd1_count", 32'(resp_dat.size()), 32'd1);
    checkOutput("rd1_cycle", respCycAt(0), 32'd4);
    checkOutput("rd1_data", respDatAt(0), 32'h105);

    // Write ignores len and touches only its own word.
    wr_allowed = 8'd9;
    wr_cnt     = 0;
    bad_wr_cnt = 0;
    applyStimulus(1'b1, 8'd9, 32'hDEADBEEF, 3'd3, 1'b0);
    runCycles(8);
    checkOutput("wr_count", 32'(resp_dat.size()), 32'd1);
    checkOutput("wr_cycle", respCycAt(0), 32'd4);
    checkOutput("wr_rdata", respDatAt(0), 32'd0);
    checkOutput("wr_mem9", mem[9], 32'hDEADBEEF);
    checkOutput("wr_mem10", mem[10], 32'h10A);
    checkOutput("wr_strobe_cycles", 32'(wr_cnt), 32'(WAIT_CYCLES));
    checkOutput("wr_bad_addr", 32'(bad_wr_cnt), 32'd0);

    // Burst across the top of memory wraps to address 0.
    applyStimulus(1'b0, 8'd254, 32'h0, 3'd4, 1'b0);
    runCycles(15);
    checkOutput("burst_count", 32'(resp_dat.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("burst_cycle%0d", i), respCycAt(i), 32'(4 + 3 * i));
      checkOutput($sformatf("burst_data%0d", i), respDatAt(i), burst_exp[i]);
    end

    applyStimulus(1'b0, 8'd20, 32'h0, 3'd0, 1'b0);
    runCycles(8);
    checkOutput("len0_count", 32'(resp_dat.size()), 32'd1);
    checkOutput("len0_data", respDatAt(0), 32'h114);

    applyStimulus(1'b0, 8'd20, 32'h0, 3'd7, 1'b0);
    runCycles(18);
    checkOutput("len7_count", 32'(resp_dat.size()), 32'd4);
    checkOutput("len7_last", respDatAt(3), 32'h117);

    // Back-to-back: second request waits in IDLE at cycle 4 and is taken at the end of it.
    applyStimulus(1'b0, 8'd1, 32'h0, 3'd1, 1'b1);
    bus.cpu_req_addr = 8'd2;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      checkOutput($sformatf("b2b_ready_c%0d", k), 32'(bus.cpu_req_ready),
                  32'((k == 4) || (k >= 8)));
      if (k == 5)
        bus.cpu_req_valid = 1'b0;
    end
    checkOutput("b2b_count", 32'(resp_dat.size()), 32'd2);
    checkOutput("b2b_cycle0", respCycAt(0), 32'd4);
    checkOutput("b2b_cycle1", respCycAt(1), 32'd8);
    checkOutput("b2b_data0", respDatAt(0), 32'h101);
    checkOutput("b2b_data1", respDatAt(1), 32'h102);

    // Reset in the middle of a write's strobe phase.
    wr_allowed = 8'd50;
    applyStimulus(1'b1, 8'd50, 32'h12345678, 3'd1, 1'b0);
    @(negedge clk);
    checkOutput("rst_setup_wr_en", 32'(bus.mem_write_en), 32'd0);
    checkOutput("rst_setup_addr", 32'(bus.mem_addr), 32'd50);
    @(negedge clk);
    checkOutput("rst_access_wr_en", 32'(bus.mem_write_en), 32'd1);
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("rst_async_wr_en", 32'(bus.mem_write_en), 32'd0);
    checkOutput("rst_async_busy", 32'(bus.busy), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    runCycles(6);
    checkOutput("rst_no_resp", 32'(resp_dat.size()), 32'd0);
    checkResetValues("post_rst");

    checkOutput("strobe_overlap", 32'(overlap_cnt), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
